// File: rtl/register_status_table_if.sv
// rtl/register_status_table_if.sv - dispatch/commit/forwarding bundle for the register status table
//
// Groups every non-clock signal of register_status_table.
//   slave  : the register status table side
//   master : decoder / ROB / testbench side
// Dispatch path : Issue, ROBFull, ROBTail, DestReg, WriteDest -> Dispatch
// Source lookup : SrcA, SrcB, ForwardA/B, ForwardDataA/B -> IndexA/B, OpA/B, ReadyA/B, TagA/B
// Commit path   : Commit, ROBHead, WE, WA, WD
interface register_status_table_if;
    logic        Issue;
    logic        ROBFull;
    logic        Dispatch;
    logic [2:0]  ROBTail;
    logic [3:0]  DestReg;
    logic        WriteDest;
    logic [3:0]  SrcA;
    logic [3:0]  SrcB;
    logic        Commit;
    logic [2:0]  ROBHead;
    logic        WE;
    logic [3:0]  WA;
    logic [31:0] WD;
    logic [2:0]  IndexA;
    logic [2:0]  IndexB;
    logic        ForwardA;
    logic        ForwardB;
    logic [31:0] ForwardDataA;
    logic [31:0] ForwardDataB;
    logic [31:0] OpA;
    logic [31:0] OpB;
    logic        ReadyA;
    logic        ReadyB;
    logic [2:0]  TagA;
    logic [2:0]  TagB;

    modport slave (
        input  Issue, ROBFull, ROBTail, DestReg, WriteDest, SrcA, SrcB,
        input  Commit, ROBHead, WE, WA, WD,
        input  ForwardA, ForwardB, ForwardDataA, ForwardDataB,
        output Dispatch, IndexA, IndexB, OpA, OpB, ReadyA, ReadyB, TagA, TagB
    );

    modport master (
        output Issue, ROBFull, ROBTail, DestReg, WriteDest, SrcA, SrcB,
        output Commit, ROBHead, WE, WA, WD,
        output ForwardA, ForwardB, ForwardDataA, ForwardDataB,
        input  Dispatch, IndexA, IndexB, OpA, OpB, ReadyA, ReadyB, TagA, TagB
    );
endinterface

// File: rtl/register_status_table.sv
// rtl/register_status_table.sv - architectural register file with busy/tag renaming and operand resolution
//
// Holds 16 x 32-bit architectural registers, a busy bit and a 3-bit ROB tag per
// register. Destinations are renamed to ROBTail on dispatch and released when
// the ROB commits the matching tag. Each source operand resolves to a ready
// value (register file, same-cycle commit bypass or ROB forward) or to the
// producer tag the reservation station must wait on.
// Ports:
//   CLK   : clock, all state updates on the rising edge
//   Reset : synchronous active-high reset
//   bus   : register_status_table_if.slave (dispatch, commit, lookup, forwarding)
module register_status_table (
    input  logic                           CLK,
    input  logic                           Reset,
    register_status_table_if.slave         bus
);
    logic [31:0] rf_q   [16];
    logic [31:0] rf_d   [16];
    logic [15:0] busy_q;
    logic [15:0] busy_d;
    logic [2:0]  tag_q  [16];
    logic [2:0]  tag_d  [16];

    logic dispatch;
    logic commit_we;

    assign dispatch  = bus.Issue & ~bus.ROBFull;
    assign commit_we = bus.Commit & bus.WE;
    assign bus.Dispatch = dispatch;

    // Returns {ready, op}. Sources see pre-edge state plus the retiring value,
    // so an instruction reading its own destination sees the old mapping.
    function automatic logic [32:0] resolve(
        input logic        busy_s,
        input logic [2:0]  tag_s,
        input logic [31:0] rf_s,
        input logic        wa_hit,
        input logic [2:0]  head,
        input logic [31:0] wd,
        input logic        fwd,
        input logic [31:0] fwd_data
    );
        logic [32:0] r;
        r = 33'd0;
        if (!busy_s) begin
            // Architectural value; a same-cycle commit to this register writes through.
            r = {1'b1, (wa_hit ? wd : rf_s)};
        end else if (wa_hit && (tag_s == head)) begin
            r = {1'b1, wd};
        end else if (fwd) begin
            r = {1'b1, fwd_data};
        end
        return r;
    endfunction

    logic [32:0] res_a;
    logic [32:0] res_b;

    always_comb begin
        res_a = resolve(busy_q[bus.SrcA], tag_q[bus.SrcA], rf_q[bus.SrcA],
                        commit_we && (bus.WA == bus.SrcA), bus.ROBHead, bus.WD,
                        bus.ForwardA, bus.ForwardDataA);
        res_b = resolve(busy_q[bus.SrcB], tag_q[bus.SrcB], rf_q[bus.SrcB],
                        commit_we && (bus.WA == bus.SrcB), bus.ROBHead, bus.WD,
                        bus.ForwardB, bus.ForwardDataB);
    end

    assign bus.ReadyA = res_a[32];
    assign bus.OpA    = res_a[31:0];
    assign bus.ReadyB = res_b[32];
    assign bus.OpB    = res_b[31:0];
    assign bus.TagA   = tag_q[bus.SrcA];
    assign bus.TagB   = tag_q[bus.SrcB];
    assign bus.IndexA = tag_q[bus.SrcA];
    assign bus.IndexB = tag_q[bus.SrcB];

    always_comb begin
        rf_d   = rf_q;
        busy_d = busy_q;
        tag_d  = tag_q;
        if (commit_we) begin
            rf_d[bus.WA] = bus.WD;
            // Only release if the register still maps to the retiring entry;
            // otherwise a younger producer owns it.
            if (busy_q[bus.WA] && (tag_q[bus.WA] == bus.ROBHead)) begin
                busy_d[bus.WA] = 1'b0;
            end
        end
        // Applied after commit so a same-register rename wins over the release.
        if (dispatch && bus.WriteDest) begin
            busy_d[bus.DestReg] = 1'b1;
            tag_d[bus.DestReg]  = bus.ROBTail;
        end
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            busy_q <= 16'd0;
            for (int i = 0; i < 16; i++) begin
                rf_q[i]  <= 32'd0;
                tag_q[i] <= 3'd0;
            end
        end else begin
            busy_q <= busy_d;
            for (int i = 0; i < 16; i++) begin
                rf_q[i]  <= rf_d[i];
                tag_q[i] <= tag_d[i];
            end
        end
    end
endmodule

// File: doc/register_status_table.md
# register_status_table

Dispatch-side operand resolver for the out-of-order core: it holds the architectural register file (16 × 32-bit) plus a per-register busy bit and ROB tag. It renames destinations to `ROBTail` at dispatch and releases them when the reorder buffer commits. For each dispatched instruction it produces either a ready 32-bit operand or the 3-bit ROB tag that reservation stations must wait on. Operands are taken from three sources: the register file, the ROB forwarding ports, or a same-cycle commit bypass.

## Interface
- `NREG`, 16: architectural registers; index width 4 bits, fixed.
- `TAGW`, 3: ROB tag width (8 entries), fixed.
- `CLK` input 1: sole clock; all state updates on its rising edge.
- `Reset` input 1: synchronous, active-high; sampled on rising `CLK`.
- `Issue` input 1: decoder presents an instruction this cycle.
- `ROBFull` input 1: ROB `full`; blocks dispatch.
- `Dispatch` output 1: `Issue & ~ROBFull`; same signal drives ROB `append`.
- `ROBTail` input 3: tag allocated to the dispatching instruction.
- `DestReg` input 4: destination architectural register.
- `WriteDest` input 1: instruction writes `DestReg` (0 for stores/branches).
- `SrcA`, `SrcB` input 4 each: source register indices.
- `Commit` input 1: ROB retires its head this cycle.
- `ROBHead` input 3: tag of the retiring entry.
- `WE` input 1: retiring entry writes the register file.
- `WA` input 4: retiring destination register.
- `WD` input 32: retiring value.
- `IndexA`, `IndexB` output 3: ROB forwarding lookup; equal to the tag of `SrcA`/`SrcB`.
- `ForwardA`, `ForwardB` input 1: the ROB entry has its result.
- `ForwardDataA`, `ForwardDataB` input 32: ROB entry value.
- `OpA`, `OpB` output 32: resolved operand value; 0 when not ready.
- `ReadyA`, `ReadyB` output 1: operand value is valid.
- `TagA`, `TagB` output 3: producer ROB tag; meaningful only when `Ready*` = 0.

## Operation
- State:
  - `RF[0:15]` (32-bit).
  - `BUSY[15:0]`.
  - `TAG[0:15]` (3-bit).
- Reset (sync): `RF` all 0, `BUSY` all 0, `TAG` all 0.
- Source resolution (combinational, per port X ∈ {A, B}, source index s), in priority order:
  1. `BUSY[s]=0` → `ReadyX=1`, `OpX=RF[s]`. If `Commit & WE & WA==s`, use `WD` instead (write-through).
  2. `BUSY[s]=1`, `Commit & WE & WA==s & TAG[s]==ROBHead` → `ReadyX=1`, `OpX=WD`.
  3. `BUSY[s]=1`, `ForwardX=1` → `ReadyX=1`, `OpX=ForwardDataX`.
  4. Otherwise → `ReadyX=0`, `OpX=0`, `TagX=TAG[s]`.
- `IndexX = TAG[s]` at all times.
- Sources read pre-dispatch state: when `DestReg==SrcA`, A resolves against the old mapping, not the instruction's own tag.
- Dispatch, on an edge with `Dispatch & WriteDest`: `BUSY[DestReg]<=1`, `TAG[DestReg]<=ROBTail`.
- Commit, on an edge with `Commit & WE`: `RF[WA]<=WD`. If additionally `BUSY[WA] & TAG[WA]==ROBHead`, then `BUSY[WA]<=0`. A tag mismatch (register already renamed to a younger entry) leaves `BUSY`/`TAG` untouched.
- Dispatch and commit on the same register in the same cycle: the dispatch update wins, giving `BUSY=1` with the new tag; `RF` is still written.
- Commit with `WE=0` changes no state.
- `Issue` with `ROBFull=1`: no state change; `Dispatch=0`.

## Timing
- Operand outputs are combinational from current state and inputs; no latency inside the cycle.
- Rename and release become visible to lookups on the cycle after the edge.
- After `Reset`:
  - `Dispatch=0` unless `Issue & ~ROBFull`.
  - `ReadyA=ReadyB=1`, `OpA=OpB=0`, `TagA=TagB=IndexA=IndexB=0`.
- `Reset` asserted mid-stream overrides dispatch and commit on that edge.
- Tag wrap-around is handled by the ROB (8 entries); at most one live tag per register is tracked.

## Test plan
- Reset, then `SrcA=3`, `SrcB=5` → `ReadyA=ReadyB=1`, `OpA=OpB=0`.
- Commit `WE=1`, `WA=3`, `WD=0x1234`, with `BUSY[3]=0` and same-cycle `SrcA=3` → `OpA=0x1234` (bypass); next cycle `RF[3]=0x1234`.
- Dispatch `DestReg=7`, `ROBTail=2` → next cycle `SrcB=7` gives `ReadyB=0`, `TagB=2`, `IndexB=2`. Then drive `ForwardB=1`, `ForwardDataB=0xBEEF` → `ReadyB=1`, `OpB=0xBEEF`.
- Rename r4 to tag 1, then to tag 3. Commit tag 1 with `WA=4`, `WD=9` → `RF[4]=9`, `BUSY[4]` stays 1, `TAG[4]=3`.
- Same cycle: commit `ROBHead=5`, `WA=6` (current tag 5) and dispatch `DestReg=6`, `ROBTail=0` → `BUSY[6]=1`, `TAG[6]=0`, `RF[6]=WD`.
- `Issue=1`, `ROBFull=1`, `DestReg=2` → `Dispatch=0`, `BUSY[2]` unchanged. Then `Reset` during a pending rename → all `Ready*=1` next cycle.
